// File: rtl/flo_dac_spi.sv
// flo_dac_spi: captures strobed 16-bit channel words and sends each one
// as a 24-bit {CMD, channel, data} SPI write frame, MSB first, with a
// one-deep holding register and a sticky overrun flag per channel.
module flo_dac_spi #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SCLK_DIV = 2,
  parameter logic [3:0]  CMD      = 4'h3
) (
  input  logic                    S_AXI_ACLK,
  input  logic                    S_AXI_ARESETN,
  input  logic [16*CHANNELS-1:0]  data_i,
  input  logic [CHANNELS-1:0]     stb_i,
  input  logic                    err_clr_i,
  output logic                    sclk_o,
  output logic                    mosi_o,
  output logic                    cs_n_o,
  output logic                    busy_o,
  output logic [CHANNELS-1:0]     err_o
);

  localparam int unsigned FRAME_W = 24;
  localparam int unsigned BIT_W   = 5;
  localparam int unsigned DIV_W   = $clog2(SCLK_DIV) + 1;
  localparam int unsigned GAP_W   = $clog2(2 * SCLK_DIV) + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_GAP
  } state_e;

  state_e                     state_q, state_d;
  logic [FRAME_W-1:0]         sh_q, sh_d;
  logic [DIV_W-1:0]           div_q, div_d;
  logic                       phase_q, phase_d;
  logic [BIT_W-1:0]           bit_q, bit_d;
  logic [GAP_W-1:0]           gap_q, gap_d;
  logic                       sclk_q, sclk_d;
  logic                       cs_n_q, cs_n_d;
  logic                       busy_q, busy_d;
  logic [CHANNELS-1:0]        pend_q, pend_d;
  logic [CHANNELS-1:0]        err_q, err_d;
  logic [CHANNELS-1:0][15:0]  hold_q, hold_d;

  logic                       any_pend_c;
  logic                       take_c;
  logic [3:0]                 sel_c;
  logic [15:0]                word_c;
  logic [CHANNELS-1:0]        consume_c;

  // Fixed-priority arbiter: lowest pending channel wins.
  always_comb begin
    any_pend_c = |pend_q;
    sel_c      = '0;
    word_c     = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        sel_c  = 4'(i);
        word_c = hold_q[i];
      end
    end
    take_c = (state_q == ST_IDLE) && any_pend_c;
  end

  // Holding registers, pending flags and sticky overrun flags; a strobe in
  // the consume cycle refills the slot since the frame takes the old word.
  always_comb begin
    pend_d    = pend_q;
    hold_d    = hold_q;
    consume_c = '0;
    err_d     = err_clr_i ? '0 : err_q;
    for (int i = 0; i < CHANNELS; i++) begin
      consume_c[i] = take_c && (sel_c == 4'(i));
      if (stb_i[i]) begin
        hold_d[i] = data_i[16*i +: 16];
        pend_d[i] = 1'b1;
        if (pend_q[i] && !consume_c[i]) begin
          err_d[i] = 1'b1;
        end
      end else if (consume_c[i]) begin
        pend_d[i] = 1'b0;
      end
    end
  end

  // Frame FSM: select in IDLE, 24 bits of 2*SCLK_DIV cycles, then CS gap.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    div_d   = div_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    sclk_d  = sclk_q;
    cs_n_d  = cs_n_q;
    case (state_q)
      ST_IDLE: begin
        if (any_pend_c) begin
          state_d = ST_SHIFT;
          sh_d    = {CMD, sel_c, word_c};
          div_d   = '0;
          phase_d = 1'b0;
          bit_d   = '0;
          sclk_d  = 1'b0;
          cs_n_d  = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (div_q == DIV_W'(SCLK_DIV - 1)) begin
          div_d = '0;
          if (!phase_q) begin
            phase_d = 1'b1;
            sclk_d  = 1'b1;
          end else begin
            phase_d = 1'b0;
            sclk_d  = 1'b0;
            if (bit_q == BIT_W'(FRAME_W - 1)) begin
              state_d = ST_GAP;
              sh_d    = '0;
              cs_n_d  = 1'b1;
              gap_d   = '0;
            end else begin
              bit_d = bit_q + BIT_W'(1);
              sh_d  = {sh_q[FRAME_W-2:0], 1'b0};
            end
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_W'(2 * SCLK_DIV - 1)) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Busy also covers the first IDLE cycle after the gap.
    busy_d = (|pend_d) || (state_q != ST_IDLE) || (state_d != ST_IDLE);
  end

  // FSM and shifter registers.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q <= ST_IDLE;
      sh_q    <= '0;
      div_q   <= '0;
      phase_q <= 1'b0;
      bit_q   <= '0;
      gap_q   <= '0;
      sclk_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      div_q   <= div_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
      busy_q  <= busy_d;
    end
  end

  // Per-channel holding, pending and error registers.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      pend_q <= '0;
      err_q  <= '0;
      hold_q <= '0;
    end else begin
      pend_q <= pend_d;
      err_q  <= err_d;
      hold_q <= hold_d;
    end
  end

  assign sclk_o = sclk_q;
  assign mosi_o = sh_q[FRAME_W-1];
  assign cs_n_o = cs_n_q;
  assign busy_o = busy_q;
  assign err_o  = err_q;

endmodule

// File: tb/tb_flo_dac_spi.sv
// Bench for flo_dac_spi: an SPI monitor rebuilds frames and checks them
// against a queue of expected frames pushed when each strobe is driven.
module tb_flo_dac_spi;

  localparam int unsigned CH = 16;
  localparam int unsigned D  = 2;
  localparam int FALL_C      = 2;
  localparam int RISE_C      = 2 + 48 * D;
  localparam int BUSY_LOW_C  = 2 + 50 * D + 1;
  localparam int CS_HIGH_GAP = 2 * D + 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [16*CH-1:0] data = '0;
  logic [CH-1:0]   stb = '0;
  logic            err_clr = 1'b0;
  logic            sclk, mosi, cs_n, busy;
  logic [CH-1:0]   err;

  flo_dac_spi #(.CHANNELS(CH), .SCLK_DIV(D), .CMD(4'h3)) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .data_i        (data),
    .stb_i         (stb),
    .err_clr_i     (err_clr),
    .sclk_o        (sclk),
    .mosi_o        (mosi),
    .cs_n_o        (cs_n),
    .busy_o        (busy),
    .err_o         (err)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          base = 0;
  int          bits = 0;
  int          idle_at;
  int          nfall;
  logic [23:0] cap = '0;
  logic        prev_cs = 1'b1;
  logic        prev_sclk = 1'b0;
  logic [23:0] exp_q[$];
  int          fall_q[$];
  int          rise_q[$];

  typedef struct {
    int          ch;
    logic [15:0] data;
    logic [23:0] frame;
  } vec_t;
  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc - base);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    failures++;
    $display("FAIL %s: unexpected at cycle %0d", name, cyc - base);
  endtask

  // Advance to the next falling edge and run the SPI monitor there.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      prev_cs   = 1'b1;
      prev_sclk = 1'b0;
      bits      = 0;
      return;
    end
    if (prev_cs && !cs_n) begin
      bits = 0;
      cap  = '0;
      fall_q.push_back(cyc);
    end
    if (!cs_n && sclk && !prev_sclk) begin
      if (exp_q.size() == 0) flag("mosi_no_frame_expected");
      else if (bits < 24) check("mosi_bit", 32'(mosi), 32'(exp_q[0][23-bits]));
      cap = {cap[22:0], mosi};
      bits++;
    end
    if (!prev_cs && cs_n) begin
      rise_q.push_back(cyc);
      check("sclk_edges", bits, 24);
      if (exp_q.size() == 0) flag("frame_not_expected");
      else check("frame", 32'(cap), 32'(exp_q.pop_front()));
    end
    prev_cs   = cs_n;
    prev_sclk = sclk;
  endtask

  task automatic drive(input int ch, input logic [15:0] d);
    stb[ch]           = 1'b1;
    data[16*ch +: 16] = d;
  endtask

  task automatic pulse();
    tick();
    stb     = '0;
    err_clr = 1'b0;
  endtask

  task automatic wait_until(input int rel);
    while ((cyc - base) < rel) tick();
  endtask

  task automatic wait_idle(input string name, input int budget, output int at);
    int n;
    n  = 0;
    at = -1;
    while (busy !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    if (busy !== 1'b0) flag(name);
    else at = cyc - base;
  endtask

  initial begin
    vecs[0] = '{ch: 2,  data: 16'hBEEF, frame: 24'h32BEEF};
    vecs[1] = '{ch: 15, data: 16'h0000, frame: 24'h3F0000};
    vecs[2] = '{ch: 15, data: 16'hFFFF, frame: 24'h3FFFFF};
    vecs[3] = '{ch: 9,  data: 16'hA5C3, frame: 24'h39A5C3};

    // Reset values.
    repeat (3) tick();
    check("rst_cs_n", 32'(cs_n), 1);
    check("rst_sclk", 32'(sclk), 0);
    check("rst_mosi", 32'(mosi), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_err", 32'(err), 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Single-strobe frames with full timing.
    for (int i = 0; i < 4; i++) begin
      fall_q.delete();
      rise_q.delete();
      base = cyc;
      drive(vecs[i].ch, vecs[i].data);
      exp_q.push_back(vecs[i].frame);
      pulse();
      check("busy_cycle1", 32'(busy), 1);
      check("cs_n_cycle1", 32'(cs_n), 1);
      wait_idle("single_timeout", 400, idle_at);
      check("busy_low_cycle", idle_at, BUSY_LOW_C);
      check("cs_fall_cycle", (fall_q.size() > 0) ? fall_q[0] - base : -1, FALL_C);
      check("cs_rise_cycle", (rise_q.size() > 0) ? rise_q[0] - base : -1, RISE_C);
      check("single_drained", exp_q.size(), 0);
    end

    // Four same-cycle strobes: priority order and inter-frame CS timing.
    fall_q.delete();
    rise_q.delete();
    base = cyc;
    for (int k = 0; k < 4; k++) begin
      drive(k, 16'hDE00 + 16'(k));
      exp_q.push_back({4'h3, 4'(k), 16'hDE00 + 16'(k)});
    end
    pulse();
    wait_idle("burst_timeout", 600, idle_at);
    check("burst_frames", fall_q.size(), 4);
    if (fall_q.size() == 4 && rise_q.size() == 4) begin
      for (int j = 0; j < 3; j++) check("burst_cs_high", fall_q[j+1] - rise_q[j], CS_HIGH_GAP);
    end
    check("burst_err", 32'(err), 0);
    check("burst_drained", exp_q.size(), 0);

    // Overwrite of a pending word, and overrun winning over a clear.
    base = cyc;
    drive(0, 16'h0123);
    exp_q.push_back(24'h300123);
    pulse();
    wait_until(10);
    drive(1, 16'h1111);
    pulse();
    wait_until(14);
    drive(1, 16'h2222);
    exp_q.push_back(24'h312222);
    pulse();
    check("overrun_err", 32'(err), 32'h0002);
    drive(2, 16'h4444);
    pulse();
    drive(2, 16'h4545);
    err_clr = 1'b1;
    exp_q.push_back(24'h324545);
    pulse();
    check("overrun_beats_clr", 32'(err), 32'h0004);
    err_clr = 1'b1;
    pulse();
    check("err_clr", 32'(err), 0);
    wait_idle("overrun_timeout", 600, idle_at);
    check("overrun_drained", exp_q.size(), 0);

    // Re-strobe a channel while its own frame shifts: no error.
    base = cyc;
    drive(0, 16'hAAAA);
    exp_q.push_back(24'h30AAAA);
    pulse();
    wait_until(23);
    drive(0, 16'h5555);
    exp_q.push_back(24'h305555);
    pulse();
    wait_idle("self_timeout", 400, idle_at);
    check("self_err", 32'(err), 0);
    check("self_drained", exp_q.size(), 0);

    // Strobe in the same cycle the channel is consumed.
    base = cyc;
    drive(3, 16'h0A0A);
    exp_q.push_back(24'h330A0A);
    pulse();
    drive(3, 16'h0B0B);
    exp_q.push_back(24'h330B0B);
    pulse();
    wait_idle("consume_timeout", 400, idle_at);
    check("consume_err", 32'(err), 0);
    check("consume_drained", exp_q.size(), 0);

    // Asynchronous reset in the high phase of bit 10.
    base = cyc;
    drive(5, 16'h3FFF);
    exp_q.push_back(24'h353FFF);
    pulse();
    wait_until(44);
    check("pre_rst_cs_n", 32'(cs_n), 0);
    check("pre_rst_sclk", 32'(sclk), 1);
    check("pre_rst_mosi", 32'(mosi), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_cs_n", 32'(cs_n), 1);
    check("async_rst_sclk", 32'(sclk), 0);
    check("async_rst_mosi", 32'(mosi), 0);
    check("async_rst_busy", 32'(busy), 0);
    exp_q.delete();
    repeat (3) tick();
    rst_n = 1'b1;
    nfall = fall_q.size();
    repeat (200) tick();
    check("post_rst_no_frame", fall_q.size(), nfall);
    check("post_rst_busy", 32'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
